// File: rtl/mdio_master_pkg.sv
// mdio_master_pkg: frame constants, state encoding and frame builder shared by the MDIO master
package mdio_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_TAIL = 3'd5
    } state_t;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;
    localparam logic [1:0] TA_WR = 2'b10;

    localparam int PRE_BITS   = 32;
    localparam int HDR_BITS   = 14;
    localparam int TA_BITS    = 2;
    localparam int DATA_BITS  = 16;
    localparam int FRAME_BITS = 65;

    // bit index of the last bit of each field
    localparam logic [6:0] PRE_END  = 7'(PRE_BITS - 1);
    localparam logic [6:0] HDR_END  = 7'(PRE_BITS + HDR_BITS - 1);
    localparam logic [6:0] TA_END   = 7'(PRE_BITS + HDR_BITS + TA_BITS - 1);
    localparam logic [6:0] DATA_END = 7'(PRE_BITS + HDR_BITS + TA_BITS + DATA_BITS - 1);
    localparam logic [6:0] TAIL_END = 7'(FRAME_BITS - 1);

    // the 32 bits that follow the preamble; TA/DATA are don't-care on reads
    function automatic logic [31:0] frame_word(
        input logic        wr,
        input logic [4:0]  phy,
        input logic [4:0]  regad,
        input logic [15:0] wdata
    );
        return {ST, wr ? OP_WR : OP_RD, phy, regad, TA_WR, wdata};
    endfunction

endpackage

// File: rtl/mdio_master_mdc_gen.sv
// mdc_gen: MDC divider; strobes the last clk cycle of every bit (bit boundary and read sample point)
module mdc_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic mdc,
    output logic bit_start,
    output logic sample
);

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [7:0] div;
    logic       at_last;

    assign at_last   = div == LAST;
    assign bit_start = en && at_last && mdc;
    assign sample    = bit_start;

    // divider held at 0 with mdc low while idle; mdc toggles every CLK_DIV cycles when running
    always_ff @(posedge clk) begin
        if (!reset_n || !en) begin
            div <= '0;
            mdc <= 1'b0;
        end else begin
            div <= at_last ? '0 : div + 8'd1;
            mdc <= at_last ? ~mdc : mdc;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// mdio_master: clause-22 MDIO management master with a single command/response handshake
module mdio_master
    import mdio_master_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    state_t      state, state_nx;
    logic [6:0]  cnt;
    logic [31:0] sr;
    logic [16:0] rd;
    logic [1:0]  sync;
    logic        is_wr;
    logic        accept;
    logic        bit_start;
    logic        sample;
    logic        drv_nx;

    assign cmd_ready = state == S_IDLE;
    assign busy      = ~cmd_ready;
    assign accept    = cmd_valid && cmd_ready;
    // whether the bit after the current one is driven by the master
    assign drv_nx    = cnt < (is_wr ? DATA_END : HDR_END);

    mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (busy),
        .mdc       (mdc),
        .bit_start (bit_start),
        .sample    (sample)
    );

    // state register
    always_ff @(posedge clk) state <= !reset_n ? S_IDLE : state_nx;

    // next state: move to the next field when the last bit of the current one ends
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_PRE;
            S_PRE:   if (bit_start && cnt == PRE_END) state_nx = S_HDR;
            S_HDR:   if (bit_start && cnt == HDR_END) state_nx = S_TA;
            S_TA:    if (bit_start && cnt == TA_END) state_nx = S_DATA;
            S_DATA:  if (bit_start && cnt == DATA_END) state_nx = S_TAIL;
            S_TAIL:  if (bit_start && cnt == TAIL_END) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // bit counter, command capture and pad drive; pad values change only at bit boundaries
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            sr      <= '0;
            is_wr   <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            sr      <= frame_word(cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata);
            is_wr   <= cmd_write;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b1;
        end else if (bit_start) begin
            cnt     <= cnt + 7'd1;
            sr      <= cnt >= PRE_END ? {sr[30:0], 1'b0} : sr;
            mdio_o  <= (cnt >= PRE_END && drv_nx) ? sr[31] : 1'b1;
            mdio_oe <= drv_nx;
        end
    end

    // two-flop synchronizer for the asynchronous pad input; idles at the pull-up level
    always_ff @(posedge clk) sync <= !reset_n ? 2'b11 : {sync[0], mdio_i};

    // read capture (TA bit 2 ends up in rd[16]) and response registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd        <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= bit_start && state == S_TAIL;
            if (sample && (state == S_TA || state == S_DATA)) rd <= {rd[15:0], sync[1]};
            if (bit_start && state == S_TAIL) begin
                rsp_rdata <= is_wr ? 16'h0 : rd[15:0];
                rsp_err   <= !is_wr && rd[16];
            end
        end
    end

endmodule
